// File: rtl/dac_playback_ctrl.sv
// Playback sequencer for a DMA-fed DAC. It splits a circular buffer into
// datamover-sized chunks, issues them one at a time, replays the buffer a
// configured number of times (or forever) and resets the DMA reader on
// start, abort and fault.
module dac_playback_ctrl #(
  parameter logic [31:0] MAX_CHUNK  = 32'h0080_0000,
  parameter int          RST_CYCLES = 8,
  parameter logic [31:0] TIMEOUT    = 32'd33_325_000
) (
  input  logic        pl_clk,
  input  logic        pl_rstb,
  input  logic        cmd_start,
  input  logic        cmd_stop,
  input  logic [31:0] cfg_base_addr,
  input  logic [31:0] cfg_total_bytes,
  input  logic [15:0] cfg_loops,
  input  logic        dm_sts_valid,
  input  logic [7:0]  dm_sts,
  input  logic        read_mm2s_err,
  output logic        read_start,
  output logic        read_reset,
  output logic [31:0] start_address,
  output logic [31:0] cap_size,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [2:0]  err_code,
  output logic [15:0] loops_done,
  output logic [3:0]  chunk_tag
);

  typedef enum logic [2:0] {
    S_IDLE, S_RST, S_ISSUE, S_WAIT, S_NEXT, S_DONE, S_FAULT
  } state_t;

  state_t      r_state, w_state_next;
  logic [31:0] r_cnt, r_tmo;
  logic        r_abort;
  logic [31:0] r_base, r_total, r_cur_addr, r_remaining;
  logic [15:0] r_loops;
  logic        r_read_start, r_read_reset, r_busy, r_done, r_err;
  logic [31:0] r_start_address, r_cap_size;
  logic [2:0]  r_err_code;
  logic [15:0] r_loops_done;
  logic [3:0]  r_chunk_tag;

  logic        w_accept, w_cfg_ok, w_sts_ok, w_sts_bad, w_cnt_end;
  logic        w_abort, w_cnt_restart, w_last_pass;
  logic [2:0]  w_fault_code;
  logic [31:0] w_chunk, w_rem_after;
  logic [15:0] w_loops_inc;
  logic        w_unused_tag;

  // The datamover tag field is not tracked; chunk_tag is generated locally.
  assign w_unused_tag = &{1'b0, dm_sts[3:0]};

  assign w_accept    = (r_state == S_IDLE) && cmd_start && !cmd_stop;
  assign w_cfg_ok    = (cfg_base_addr[4:0] == 5'd0) && (cfg_total_bytes[4:0] == 5'd0) &&
                       (cfg_total_bytes != 32'd0);
  assign w_sts_ok    = dm_sts_valid && dm_sts[7] && (dm_sts[6:4] == 3'b000);
  assign w_sts_bad   = dm_sts_valid && (dm_sts[6:4] != 3'b000);
  assign w_cnt_end   = (r_cnt == 32'(RST_CYCLES - 1));
  assign w_chunk     = (r_remaining > MAX_CHUNK) ? MAX_CHUNK : r_remaining;
  assign w_rem_after = r_remaining - r_cap_size;
  assign w_loops_inc = (r_loops_done == 16'hFFFF) ? r_loops_done : r_loops_done + 16'd1;
  assign w_last_pass = (r_loops != 16'd0) && (w_loops_inc == r_loops);

  // Next-state selection; an abort reuses RST with r_abort steering the exit to IDLE.
  always_comb begin
    w_state_next  = r_state;
    w_fault_code  = 3'd0;
    w_abort       = 1'b0;
    w_cnt_restart = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_cfg_ok) begin
            w_state_next = S_RST;
          end else begin
            w_state_next = S_FAULT;
            w_fault_code = 3'd1;
          end
        end
      end
      S_RST: begin
        if (cmd_stop) begin
          w_abort       = 1'b1;
          w_cnt_restart = 1'b1;
        end else if (w_cnt_end) begin
          w_state_next = r_abort ? S_IDLE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (cmd_stop) begin
          w_state_next = S_RST;
          w_abort      = 1'b1;
        end else begin
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cmd_stop) begin
          w_state_next = S_RST;
          w_abort      = 1'b1;
        end else if (read_mm2s_err) begin
          w_state_next = S_FAULT;
          w_fault_code = 3'd3;
        end else if (w_sts_bad) begin
          w_state_next = S_FAULT;
          w_fault_code = 3'd2;
        end else if (w_sts_ok) begin
          w_state_next = S_NEXT;
        end else if (r_tmo == TIMEOUT - 32'd1) begin
          w_state_next = S_FAULT;
          w_fault_code = 3'd4;
        end
      end
      S_NEXT: begin
        if (cmd_stop) begin
          w_state_next = S_RST;
          w_abort      = 1'b1;
        end else if (w_rem_after == 32'd0 && w_last_pass) begin
          w_state_next = S_DONE;
        end else begin
          w_state_next = S_ISSUE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      S_FAULT: if (w_cnt_end) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register, counters, config latch, datapath and registered outputs.
  always_ff @(posedge pl_clk or negedge pl_rstb) begin
    if (!pl_rstb) begin
      r_state         <= S_IDLE;
      r_cnt           <= 32'd0;
      r_tmo           <= 32'd0;
      r_abort         <= 1'b0;
      r_base          <= 32'd0;
      r_total         <= 32'd0;
      r_loops         <= 16'd0;
      r_cur_addr      <= 32'd0;
      r_remaining     <= 32'd0;
      r_read_start    <= 1'b0;
      r_read_reset    <= 1'b0;
      r_start_address <= 32'd0;
      r_cap_size      <= 32'd0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_err           <= 1'b0;
      r_err_code      <= 3'd0;
      r_loops_done    <= 16'd0;
      r_chunk_tag     <= 4'd0;
    end else begin
      r_state      <= w_state_next;
      r_busy       <= (w_state_next != S_IDLE);
      r_read_reset <= (w_state_next == S_RST) || (w_state_next == S_FAULT);
      r_read_start <= (r_state == S_ISSUE) && (w_state_next == S_WAIT);
      r_done       <= (r_state == S_NEXT) && (w_state_next == S_DONE);

      if (w_state_next != r_state || w_cnt_restart) r_cnt <= 32'd0;
      else if (r_state == S_RST || r_state == S_FAULT) r_cnt <= r_cnt + 32'd1;

      if (w_abort) r_abort <= 1'b1;
      else if (r_state == S_RST && w_state_next != S_RST) r_abort <= 1'b0;

      if (w_accept) begin
        r_err      <= !w_cfg_ok;
        r_err_code <= w_cfg_ok ? 3'd0 : 3'd1;
        if (w_cfg_ok) begin
          r_base       <= cfg_base_addr;
          r_total      <= cfg_total_bytes;
          r_loops      <= cfg_loops;
          r_cur_addr   <= cfg_base_addr;
          r_remaining  <= cfg_total_bytes;
          r_loops_done <= 16'd0;
          r_chunk_tag  <= 4'd0;
        end
      end else if (r_state == S_WAIT && w_state_next == S_FAULT) begin
        r_err      <= 1'b1;
        r_err_code <= w_fault_code;
      end

      if (r_state == S_ISSUE) begin
        r_start_address <= r_cur_addr;
        r_cap_size      <= w_chunk;
        r_tmo           <= 32'd0;
      end else if (r_state == S_WAIT) begin
        r_tmo <= r_tmo + 32'd1;
      end

      if (r_state == S_NEXT && !cmd_stop) begin
        r_chunk_tag <= r_chunk_tag + 4'd1;
        if (w_rem_after != 32'd0) begin
          r_cur_addr  <= r_cur_addr + r_cap_size;
          r_remaining <= w_rem_after;
        end else begin
          r_loops_done <= w_loops_inc;
          r_cur_addr   <= r_base;
          r_remaining  <= r_total;
        end
      end
    end
  end

  assign read_start    = r_read_start;
  assign read_reset    = r_read_reset;
  assign start_address = r_start_address;
  assign cap_size      = r_cap_size;
  assign busy          = r_busy;
  assign done          = r_done;
  assign err           = r_err;
  assign err_code      = r_err_code;
  assign loops_done    = r_loops_done;
  assign chunk_tag     = r_chunk_tag;

endmodule

// File: tb/tb_dac_playback_ctrl.sv
// Directed bench for dac_playback_ctrl: expected chunk commands are queued
// as stimulus is driven and compared as read_start pulses appear.
module tb_dac_playback_ctrl;

  localparam int TMO = 100;

  logic        pl_clk = 1'b0;
  logic        pl_rstb = 1'b0;
  logic        cmd_start = 1'b0, cmd_stop = 1'b0;
  logic [31:0] cfg_base_addr = 32'd0, cfg_total_bytes = 32'd0;
  logic [15:0] cfg_loops = 16'd0;
  logic        dm_sts_valid = 1'b0;
  logic [7:0]  dm_sts = 8'd0;
  logic        read_mm2s_err = 1'b0;
  logic        read_start, read_reset, busy, done, err;
  logic [31:0] start_address, cap_size;
  logic [2:0]  err_code;
  logic [15:0] loops_done;
  logic [3:0]  chunk_tag;
  logic [91:0] outs;

  dac_playback_ctrl #(.TIMEOUT(TMO)) dut (
    .pl_clk(pl_clk), .pl_rstb(pl_rstb), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
    .cfg_base_addr(cfg_base_addr), .cfg_total_bytes(cfg_total_bytes), .cfg_loops(cfg_loops),
    .dm_sts_valid(dm_sts_valid), .dm_sts(dm_sts), .read_mm2s_err(read_mm2s_err),
    .read_start(read_start), .read_reset(read_reset), .start_address(start_address),
    .cap_size(cap_size), .busy(busy), .done(done), .err(err), .err_code(err_code),
    .loops_done(loops_done), .chunk_tag(chunk_tag)
  );

  always #5 pl_clk = ~pl_clk;

  assign outs = {read_start, read_reset, start_address, cap_size, busy, done, err,
                 err_code, loops_done, chunk_tag};

  int n_assert = 0, n_fail = 0, n_starts = 0, n_done = 0, rr_cycles = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: sample just after each rising edge, score commands, count pulses.
  always @(posedge pl_clk) begin
    #1;
    if (read_start === 1'b1) begin
      n_starts++;
      n_assert++;
      assert (exp_q.size() > 0) else begin
        n_fail++;
        $error("FAIL cmd_queue: observed addr=%0h cap=%0h expected=no command", start_address, cap_size);
      end
      if (exp_q.size() > 0) check("cmd", {32'd0, start_address, cap_size}, {32'd0, exp_q.pop_front()});
    end
    if (done === 1'b1) n_done++;
    if (read_reset === 1'b1) rr_cycles++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge pl_clk);
  endtask

  task automatic start(input logic [31:0] base, input logic [31:0] total, input logic [15:0] loops);
    @(negedge pl_clk);
    cfg_base_addr = base; cfg_total_bytes = total; cfg_loops = loops; cmd_start = 1'b1;
    @(negedge pl_clk);
    cmd_start = 1'b0;
  endtask

  task automatic wait_cmd(input string tag);
    int s = n_starts;
    int k = 0;
    while (n_starts == s && k < 300) begin
      @(negedge pl_clk);
      k++;
    end
    check(tag, 96'(n_starts != s), 96'd1);
  endtask

  task automatic send_sts(input logic [7:0] v);
    dm_sts_valid = 1'b1; dm_sts = v;
    @(negedge pl_clk);
    dm_sts_valid = 1'b0; dm_sts = 8'd0;
  endtask

  task automatic wait_idle(input string tag, input int max);
    int k = 0;
    while (busy && k < max) begin
      @(negedge pl_clk);
      k++;
    end
    check(tag, 96'(busy), 96'd0);
  endtask

  initial begin
    int d0, s0;

    // Reset state
    tick(3);
    check("reset_outputs", 96'(outs), 96'd0);
    @(negedge pl_clk) pl_rstb = 1'b1;
    tick(2);

    // Single chunk
    d0 = n_done; rr_cycles = 0;
    exp_q.push_back({32'h1000_0000, 32'h0000_4000});
    start(32'h1000_0000, 32'h4000, 16'd1);
    check("t1_busy", 96'(busy), 96'd1);
    wait_cmd("t1_cmd_seen");
    check("t1_rr_cycles", 96'(rr_cycles), 96'd8);
    send_sts(8'h80);
    wait_idle("t1_idle", 50);
    check("t1_done", 96'(n_done - d0), 96'd1);
    check("t1_loops", 96'(loops_done), 96'd1);
    check("t1_err", 96'(err), 96'd0);

    // Split into three max-size chunks
    d0 = n_done;
    exp_q.push_back({32'h2000_0000, 32'h0080_0000});
    exp_q.push_back({32'h2080_0000, 32'h0080_0000});
    exp_q.push_back({32'h2100_0000, 32'h0080_0000});
    start(32'h2000_0000, 32'h0180_0000, 16'd1);
    for (int i = 0; i < 3; i++) begin
      wait_cmd("t2_cmd_seen");
      send_sts(8'h80);
    end
    wait_idle("t2_idle", 50);
    check("t2_tag", 96'(chunk_tag), 96'd3);
    check("t2_done", 96'(n_done - d0), 96'd1);

    // Three passes of a small buffer
    d0 = n_done;
    for (int i = 0; i < 3; i++) exp_q.push_back({32'h3000_0000, 32'h0000_0100});
    start(32'h3000_0000, 32'h100, 16'd3);
    for (int i = 0; i < 3; i++) begin
      wait_cmd("t3_cmd_seen");
      send_sts(8'h80);
    end
    wait_idle("t3_idle", 50);
    check("t3_loops", 96'(loops_done), 96'd3);
    check("t3_tag", 96'(chunk_tag), 96'd3);
    check("t3_done", 96'(n_done - d0), 96'd1);

    // Infinite looping until stop
    for (int i = 0; i < 5; i++) exp_q.push_back({32'h3000_0000, 32'h0000_0100});
    start(32'h3000_0000, 32'h100, 16'd0);
    for (int i = 0; i < 4; i++) begin
      wait_cmd("t4_cmd_seen");
      send_sts(8'h80);
    end
    wait_cmd("t4_cmd5_seen");
    d0 = n_done; rr_cycles = 0;
    cmd_stop = 1'b1;
    @(negedge pl_clk) cmd_stop = 1'b0;
    wait_idle("t4_idle", 50);
    check("t4_rr_cycles", 96'(rr_cycles), 96'd8);
    check("t4_done", 96'(n_done - d0), 96'd0);
    check("t4_err", 96'(err), 96'd0);
    check("t4_loops", 96'(loops_done), 96'd4);

    // Slave error status
    d0 = n_done;
    exp_q.push_back({32'h4000_0000, 32'h0000_0100});
    start(32'h4000_0000, 32'h100, 16'd1);
    wait_cmd("t5_cmd_seen");
    rr_cycles = 0;
    send_sts(8'h40);
    wait_idle("t5_idle", 50);
    check("t5_err", 96'(err), 96'd1);
    check("t5_code", 96'(err_code), 96'd2);
    check("t5_rr_cycles", 96'(rr_cycles), 96'd8);
    check("t5_done", 96'(n_done - d0), 96'd0);

    // mm2s error and bad status together: mm2s wins; start clears old error
    exp_q.push_back({32'h4000_0000, 32'h0000_0100});
    start(32'h4000_0000, 32'h100, 16'd1);
    check("t6_err_cleared", 96'({err, err_code}), 96'd0);
    wait_cmd("t6_cmd_seen");
    rr_cycles = 0;
    read_mm2s_err = 1'b1;
    send_sts(8'hA0);
    read_mm2s_err = 1'b0;
    wait_idle("t6_idle", 50);
    check("t6_code", 96'(err_code), 96'd3);
    check("t6_rr_cycles", 96'(rr_cycles), 96'd8);

    // Timeout
    exp_q.push_back({32'h4000_0000, 32'h0000_0100});
    start(32'h4000_0000, 32'h100, 16'd1);
    wait_cmd("t7_cmd_seen");
    rr_cycles = 0;
    wait_idle("t7_idle", TMO + 50);
    check("t7_err", 96'(err), 96'd1);
    check("t7_code", 96'(err_code), 96'd4);
    check("t7_rr_cycles", 96'(rr_cycles), 96'd8);

    // Bad configs
    s0 = n_starts;
    start(32'h5000_0000, 32'h10, 16'd1);
    wait_idle("t8a_idle", 30);
    check("t8a_code", 96'({err, err_code}), 96'h9);
    start(32'h5000_0008, 32'h100, 16'd1);
    wait_idle("t8b_idle", 30);
    check("t8b_code", 96'({err, err_code}), 96'h9);
    check("t8_no_cmd", 96'(n_starts - s0), 96'd0);

    // Start and stop together in IDLE: stop wins, nothing starts, error untouched
    @(negedge pl_clk);
    cfg_base_addr = 32'h6000_0000; cfg_total_bytes = 32'h100; cfg_loops = 16'd1;
    cmd_start = 1'b1; cmd_stop = 1'b1;
    @(negedge pl_clk);
    cmd_start = 1'b0; cmd_stop = 1'b0;
    check("t10_busy", 96'(busy), 96'd0);
    tick(12);
    check("t10_no_cmd", 96'(n_starts - s0), 96'd0);
    check("t10_err_kept", 96'({err, err_code}), 96'h9);

    // cmd_start while busy is ignored
    d0 = n_done;
    exp_q.push_back({32'h6000_0000, 32'h0000_0100});
    start(32'h6000_0000, 32'h100, 16'd1);
    wait_cmd("t9_cmd_seen");
    start(32'h7000_0000, 32'h200, 16'd2);
    send_sts(8'h80);
    wait_idle("t9_idle", 50);
    check("t9_done", 96'(n_done - d0), 96'd1);
    check("t9_loops", 96'(loops_done), 96'd1);
    check("t9_err", 96'(err), 96'd0);

    // Asynchronous reset in WAIT
    d0 = n_done;
    exp_q.push_back({32'h6000_0000, 32'h0000_0100});
    start(32'h6000_0000, 32'h100, 16'd1);
    wait_cmd("t11_cmd_seen");
    #2 pl_rstb = 1'b0;
    #1 check("t11_async_reset", 96'(outs), 96'd0);
    @(negedge pl_clk) pl_rstb = 1'b1;
    tick(12);
    check("t11_idle", 96'(busy), 96'd0);
    check("t11_done", 96'(n_done - d0), 96'd0);
    check("queue_empty", 96'(exp_q.size()), 96'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
